if_prefetch: RTL and testbench

Instruction prefetch stage that sits directly upstream of the simulation RAM's PC read port. It drives `pc_re_o`/`pc_raddr_o` into the RAM and captures the combinationally returned instruction word. Fetched {address, instruction} pairs go into a small FIFO, which feeds decode over a valid/ready handshake. Jumps from execute flush the buffer and redirect fetch.

---
 rtl/if_prefetch.sv | 64 ++++++
 tb/tb_if_prefetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// if_prefetch: fetches from the PC RAM port into a small {addr, inst} FIFO feeding decode;
// a jump from execute flushes the FIFO and redirects fetch.
module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        pc_re_o,
    output logic [31:0] pc_raddr_o,
    input  logic [31:0] pc_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, empty;

    assign empty        = count == '0;
    assign pc_raddr_o   = fetch_pc;
    assign pc_re_o      = !rst && !jump_flag_i && !hold_i && count != FULL;
    assign inst_valid_o = !empty && !jump_flag_i;
    assign inst_o       = empty ? INST_NOP : mem[rd_ptr][31:0];
    assign inst_addr_o  = empty ? 32'h0 : mem[rd_ptr][63:32];
    assign push         = pc_re_o;
    assign pop          = inst_valid_o && inst_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (jump_flag_i) begin
            // misaligned targets are forced to word alignment
            fetch_pc <= jump_addr_i & ~32'h3;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {fetch_pc, pc_rdata_i};
    end
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed scenario tests for if_prefetch against a simple RAM model.
module tb_if_prefetch;
    logic        clk = 0;
    logic        rst = 1;
    logic        jump_flag_i = 0;
    logic [31:0] jump_addr_i = 0;
    logic        hold_i = 0;
    logic        pc_re_o;
    logic [31:0] pc_raddr_o;
    logic [31:0] pc_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_ready_i = 1;
    int vecs = 0;
    int errs = 0;

    if_prefetch #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_i(hold_i), .pc_re_o(pc_re_o), .pc_raddr_o(pc_raddr_o), .pc_rdata_i(pc_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .inst_ready_i(inst_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    assign pc_rdata_i = word(pc_raddr_o);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1;
        jump_flag_i = 0;
        hold_i = 0;
        inst_ready_i = rdy;
        repeat (2) step();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        #1;
        vecs++;
        if ({pc_re_o, inst_valid_o} !== 2'b00) begin
            errs++; $display("FAIL reset_ctl re/valid=%b want 00", {pc_re_o, inst_valid_o});
        end
        vecs++;
        if (inst_o !== 32'h13 || inst_addr_o !== 32'h0 || pc_raddr_o !== 32'h0) begin
            errs++; $display("FAIL reset_out inst=%h addr=%h raddr=%h want 13/0/0", inst_o, inst_addr_o, pc_raddr_o);
        end
    endtask

    task automatic test_stream();
        do_reset(1);
        vecs++;
        if (pc_re_o !== 1 || pc_raddr_o !== 32'h0 || inst_valid_o !== 0) begin
            errs++; $display("FAIL stream_c0 re=%b raddr=%h valid=%b want 1/0/0", pc_re_o, pc_raddr_o, inst_valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++;
            if (pc_raddr_o !== 32'(4 * (i + 1)) || inst_valid_o !== 1 || inst_addr_o !== 32'(4 * i)
                || inst_o !== word(32'(4 * i))) begin
                errs++; $display("FAIL stream_%0d raddr=%h valid=%b head=(%h,%h) want raddr=%h head=(%h,%h)",
                    i, pc_raddr_o, inst_valid_o, inst_addr_o, inst_o, 4 * (i + 1), 4 * i, word(32'(4 * i)));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(0);
        for (int k = 0; k < 10; k++) begin
            vecs++;
            if (pc_re_o !== (k < 4) || (k < 4 && pc_raddr_o !== 32'(4 * k))) begin
                errs++; $display("FAIL bp_fetch_%0d re=%b raddr=%h want re=%b raddr=%h", k, pc_re_o, pc_raddr_o, k < 4, 4 * k);
            end
            vecs++;
            if (inst_valid_o !== (k >= 1) || (k >= 1 && (inst_addr_o !== 32'h0 || inst_o !== word(0)))) begin
                errs++; $display("FAIL bp_head_%0d valid=%b head=(%h,%h) want (0,%h)", k, inst_valid_o, inst_addr_o, inst_o, word(0));
            end
            step();
        end
        inst_ready_i = 1;
        #1;
        for (int j = 0; j < 5; j++) begin
            vecs++;
            if (inst_valid_o !== 1 || inst_addr_o !== 32'(4 * j) || inst_o !== word(32'(4 * j))) begin
                errs++; $display("FAIL bp_drain_%0d head=(%h,%h) want (%h,%h)", j, inst_addr_o, inst_o, 4 * j, word(32'(4 * j)));
            end
            vecs++;
            if (pc_re_o !== (j >= 1) || (j >= 1 && pc_raddr_o !== 32'(16 + 4 * (j - 1)))) begin
                errs++; $display("FAIL bp_resume_%0d re=%b raddr=%h want re=%b raddr=%h", j, pc_re_o, pc_raddr_o, j >= 1, 16 + 4 * (j - 1));
            end
            step();
        end
    endtask

    task automatic test_jump();
        do_reset(0);
        repeat (3) step();
        jump_flag_i = 1;
        jump_addr_i = 32'h103;
        #1;
        vecs++;
        if (inst_valid_o !== 0 || pc_re_o !== 0) begin
            errs++; $display("FAIL jump_cycle valid=%b re=%b want 0/0", inst_valid_o, pc_re_o);
        end
        step();
        jump_flag_i = 0;
        #1;
        vecs++;
        if (inst_valid_o !== 0 || pc_re_o !== 1 || pc_raddr_o !== 32'h100) begin
            errs++; $display("FAIL jump_next valid=%b re=%b raddr=%h want 0/1/100", inst_valid_o, pc_re_o, pc_raddr_o);
        end
        step();
        vecs++;
        if (inst_valid_o !== 1 || inst_addr_o !== 32'h100 || inst_o !== 32'hA000_0040) begin
            errs++; $display("FAIL jump_target valid=%b head=(%h,%h) want (100,a0000040)", inst_valid_o, inst_addr_o, inst_o);
        end
        inst_ready_i = 1;
        step();
        vecs++;
        if (inst_valid_o !== 1 || inst_addr_o !== 32'h104 || inst_o !== 32'hA000_0041) begin
            errs++; $display("FAIL jump_follow head=(%h,%h) want (104,a0000041)", inst_addr_o, inst_o);
        end
    endtask

    task automatic test_hold();
        do_reset(0);
        repeat (2) step();
        hold_i = 1;
        inst_ready_i = 1;
        #1;
        for (int k = 0; k < 5; k++) begin
            vecs++;
            if (pc_re_o !== 0 || pc_raddr_o !== 32'h8 || inst_valid_o !== (k < 2)
                || (k < 2 && inst_addr_o !== 32'(4 * k))) begin
                errs++; $display("FAIL hold_%0d re=%b raddr=%h valid=%b head=%h want re=0 raddr=8 valid=%b head=%h",
                    k, pc_re_o, pc_raddr_o, inst_valid_o, inst_addr_o, k < 2, 4 * k);
            end
            step();
        end
        hold_i = 0;
        #1;
        vecs++;
        if (pc_re_o !== 1 || pc_raddr_o !== 32'h8) begin
            errs++; $display("FAIL hold_release re=%b raddr=%h want 1/8", pc_re_o, pc_raddr_o);
        end
        step();
        vecs++;
        if (inst_valid_o !== 1 || inst_addr_o !== 32'h8 || inst_o !== word(32'h8)) begin
            errs++; $display("FAIL hold_resume head=(%h,%h) want (8,%h)", inst_addr_o, inst_o, word(32'h8));
        end
    endtask

    task automatic test_wrap();
        do_reset(1);
        jump_flag_i = 1;
        jump_addr_i = 32'hFFFF_FFFC;
        step();
        jump_flag_i = 0;
        #1;
        vecs++;
        if (pc_re_o !== 1 || pc_raddr_o !== 32'hFFFF_FFFC) begin
            errs++; $display("FAIL wrap_fetch re=%b raddr=%h want 1/fffffffc", pc_re_o, pc_raddr_o);
        end
        step();
        vecs++;
        if (pc_raddr_o !== 32'h0 || inst_valid_o !== 1 || inst_addr_o !== 32'hFFFF_FFFC || inst_o !== 32'hDFFF_FFFF) begin
            errs++; $display("FAIL wrap_head0 raddr=%h head=(%h,%h) want raddr=0 head=(fffffffc,dfffffff)", pc_raddr_o, inst_addr_o, inst_o);
        end
        step();
        vecs++;
        if (pc_raddr_o !== 32'h4 || inst_valid_o !== 1 || inst_addr_o !== 32'h0 || inst_o !== 32'hA000_0000) begin
            errs++; $display("FAIL wrap_head1 raddr=%h head=(%h,%h) want raddr=4 head=(0,a0000000)", pc_raddr_o, inst_addr_o, inst_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset(0);
        repeat (3) step();
        #2;
        rst = 1;
        #1;
        vecs++;
        if (inst_valid_o !== 0 || inst_o !== 32'h13 || pc_re_o !== 0 || inst_addr_o !== 32'h0 || pc_raddr_o !== 32'h0) begin
            errs++; $display("FAIL areset valid=%b inst=%h re=%b addr=%h raddr=%h want 0/13/0/0/0",
                inst_valid_o, inst_o, pc_re_o, inst_addr_o, pc_raddr_o);
        end
        #2;
        rst = 0;
        #1;
        vecs++;
        if (pc_re_o !== 1 || pc_raddr_o !== 32'h0) begin
            errs++; $display("FAIL areset_release re=%b raddr=%h want 1/0", pc_re_o, pc_raddr_o);
        end
        step();
        vecs++;
        if (inst_valid_o !== 1 || inst_addr_o !== 32'h0 || inst_o !== word(0) || pc_raddr_o !== 32'h4) begin
            errs++; $display("FAIL areset_refetch head=(%h,%h) raddr=%h want (0,%h) raddr=4", inst_addr_o, inst_o, pc_raddr_o, word(0));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_jump();
        test_hold();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
